// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the 16-bit core front end: opcode constants,
// fetch state encoding and default bus widths.
package instr_fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    // Opcodes in inst[15:12]. The control decoder uses the same values.
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    // Returns 1 when the opcode field of an instruction word is HLT.
    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem request at a
// time, presents the fetched word to the decoder over valid/ready, squashes
// wrong-path responses on redirect and stops for good once HLT is accepted.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst,
    output logic [3:0]         inst_opcode,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic [ADDR_W-1:0]  inst_pc_plus2,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              drop;     // outstanding response belongs to a squashed path
    logic [ADDR_W-1:0] tgt;

    // Instructions are halfword aligned, so the low target bit is ignored.
    assign tgt = redirect_target & ~ADDR_W'(1);

    assign inst_opcode = inst[INSTR_W-1 -: 4];

    // Fetch state machine; every output except inst_opcode is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            inst_pc_plus2 <= '0;
            halted        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_valid) begin
                        if (redirect_valid) begin
                            // Response arrived with the redirect: drop it and
                            // request the target next cycle.
                            pc        <= tgt;
                            imem_addr <= tgt;
                            drop      <= 1'b0;
                        end else if (drop) begin
                            // Wrong-path response; pc already holds the target.
                            drop      <= 1'b0;
                            imem_addr <= pc;
                        end else begin
                            inst          <= imem_rdata;
                            inst_pc       <= pc;
                            inst_pc_plus2 <= pc + PC_STEP;
                            pc            <= pc + PC_STEP;
                            inst_valid    <= 1'b1;
                            imem_req      <= 1'b0;
                            state         <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Keep the address stable until the old request
                        // completes, then discard its data.
                        pc   <= tgt;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        // Redirect beats a same-cycle handshake.
                        inst_valid <= 1'b0;
                        pc         <= tgt;
                        imem_req   <= 1'b1;
                        imem_addr  <= tgt;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (is_halt(inst_opcode)) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            state     <= REQ;
                        end
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the 16-bit core. Holds the PC, issues requests to instruction memory, and accepts variable-latency responses. Presents each fetched word, with its opcode field, to the opcode control decoder over a valid/ready handshake. Accepts redirects (taken B/BR) from the branch resolver, squashes wrong-path fetches, and stops permanently on HLT.

Parameters:
ADDR_W, 16, PC / memory address width (byte addressed)
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
imem_req  out  1  fetch request; held high until imem_valid
imem_addr  out  ADDR_W  fetch address; stable while imem_req is high
imem_valid  in  1  response strobe; one cycle per request; latency >= 1 cycle after the req cycle
imem_rdata  in  INSTR_W  response data; qualified by imem_valid
inst_valid  out  1  fetched instruction available to the decoder
inst_ready  in  1  decoder/stage accepts the instruction
inst  out  INSTR_W  fetched instruction word
inst_opcode  out  4  inst[15:12]; drives the control decoder opcode input
inst_pc  out  ADDR_W  address of inst
inst_pc_plus2  out  ADDR_W  inst_pc + 2, mod 2^ADDR_W (PCS source)
redirect_valid  in  1  taken branch; pulse
redirect_target  in  ADDR_W  new PC; bit 0 is forced to 0 internally
halted  out  1  HLT accepted; fetch stopped

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, pc=RESET_PC, drop=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus2=0, halted=0.
  - Reset mid-transaction abandons it. A late imem_valid arriving in IDLE or after reset is ignored.
- States:
  - IDLE: one cycle after reset, then REQ.
  - REQ: imem_req=1, imem_addr=pc. Wait for imem_valid.
  - HOLD: inst_valid=1, outputs stable until handshake.
  - HALT: all outputs quiet except halted=1.
- REQ, imem_valid=1 and drop=0:
  - Capture inst=imem_rdata, inst_pc=pc, inst_pc_plus2=pc+2.
  - pc <= pc+2 (16'hFFFE wraps to 16'h0000).
  - Go to HOLD. imem_req drops the same cycle the state changes.
- REQ, imem_valid=1 and drop=1: discard the data, clear drop, stay in REQ with imem_addr=pc. imem_req stays high, so a new request issues the next cycle.
- Redirect in REQ:
  - Outstanding request (req high, no valid yet) and no valid in the same cycle: pc <= target, drop <= 1. The current request completes at the old address and is discarded.
  - Same cycle as imem_valid: the response is discarded, pc <= target, drop stays 0, new request next cycle.
- Redirect in HOLD: the held instruction is discarded even if inst_ready=1 that cycle (redirect wins). pc <= target, go to REQ.
- Handshake in HOLD (inst_valid & inst_ready, no redirect):
  - inst_opcode == 4'hF (HLT): go to HALT, halted=1 next cycle, no further requests.
  - Otherwise: go to REQ next cycle. Throughput is 1 instruction per (mem latency + 2) cycles; no prefetch.
- HALT: redirect_valid and imem_valid are ignored. Only reset exits.
- A HLT discarded by a redirect does not halt.
- inst_valid never drops without a handshake or redirect. inst, inst_pc, inst_pc_plus2 are unchanged while inst_valid=1 and inst_ready=0.
- Outputs are registered. Exception: inst_opcode is a wire slice of the registered inst.

Decomposition:
- Shared package: opcode constants OP_B=4'hC, OP_BR=4'hD, OP_PCS=4'hE, OP_HLT=4'hF; fetch state enum {IDLE, REQ, HOLD, HALT}; INSTR_W/ADDR_W defaults. The control decoder uses the same opcode constants.
- Single module; no sub-module warranted.

Test Plan:
1. Reset, memory latency 1, inst_ready tied 1, words A000,B0FF,0123 at 0,2,4 -> imem_addr 0,2,4 in order; inst_pc 0,2,4; inst_pc_plus2 2,4,6; inst_opcode A,B,0.
2. inst_ready held 0 for 5 cycles in HOLD -> inst_valid stays 1, inst/inst_pc unchanged, imem_req stays 0; advances one cycle after ready=1.
3. Latency 3, redirect_target=0x0041 one cycle after req at 0x0002 -> response for 0x0002 never appears on inst; next imem_addr=0x0040; inst_pc=0x0040.
4. Redirect in HOLD with inst_ready=1 same cycle, target 0x0100 -> held instruction squashed (no handshake counted); next request at 0x0100.
5. Fetch F000 at 0x0006, accept -> halted=1 next cycle; imem_req stays 0 for 20 cycles; redirects ignored. Repeat with a redirect while F000 is held -> no halt, fetch resumes at target.
6. Start with RESET_PC=16'hFFFE -> first fetch 0xFFFE, inst_pc_plus2=0x0000, next imem_addr=0x0000. Assert rst_n=0 mid-REQ, then a late imem_valid -> ignored; fetch restarts at RESET_PC.
